// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package for the hazard controller: FSM state type, its
// encodings and the width of the optional performance counters.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  localparam int PERF_W = 16;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write. Register 0 never creates a dependency.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  output logic       load_use
);

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/hold FSM with a pending-branch flag.
// Define HAZARD_PERF_EN to add saturating Stall_Count and Flush_Count outputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              ID_Jump,
  input  logic [4:0]        EX_Rt,
  input  logic              EX_MemRead,
  input  logic              MEM_BranchTaken,
  input  logic              DMEM_Busy,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_FLUSH,
  output logic              IDEX_FLUSH,
  output logic              EXMEM_FLUSH,
  output logic              Pipe_Hold,
  output logic [1:0]        Ctrl_State
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] Stall_Count,
  output logic [PERF_W-1:0] Flush_Count
`endif
);

  state_t state, next_state;
  logic   pending, next_pending;
  logic   load_use;

  hazard_detect u_detect (
    .id_rs       (ID_Rs),
    .id_rt       (ID_Rt),
    .id_uses_rt  (ID_UsesRt),
    .ex_rt       (EX_Rt),
    .ex_mem_read (EX_MemRead),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      pending <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= next_pending;
    end
  end

  always_comb begin
    next_state   = RUN;
    next_pending = pending;
    case (state)
      RUN: begin
        if (DMEM_Busy) begin
          next_state   = MEM_WAIT;
          next_pending = MEM_BranchTaken;
        end else if (MEM_BranchTaken) begin
          next_state = REDIRECT;
        end
      end
      MEM_WAIT: begin
        if (DMEM_Busy) begin
          next_state   = MEM_WAIT;
          next_pending = pending | MEM_BranchTaken;
        end else begin
          next_state   = (pending || MEM_BranchTaken) ? REDIRECT : RUN;
          next_pending = 1'b0;
        end
      end
      REDIRECT: next_state = RUN;
      default: begin
        next_state   = RUN;
        next_pending = 1'b0;
      end
    endcase
  end

  // Outputs depend only on registered state and pipeline-flop inputs, so the
  // level-sensitive ID/EX flush never sees a combinational glitch.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    Pipe_Hold   = 1'b0;
    if (!reset) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      EXMEM_FLUSH = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (DMEM_Busy) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            Pipe_Hold  = 1'b1;
          end else if (MEM_BranchTaken) begin
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
          end else if (load_use) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_FLUSH = 1'b1;
          end else if (ID_Jump) begin
            IFID_FLUSH = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (DMEM_Busy) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            Pipe_Hold  = 1'b1;
          end else if (pending || MEM_BranchTaken) begin
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
          end
        end
        REDIRECT: IFID_FLUSH = 1'b1;
        default: ;
      endcase
    end
  end

  assign Ctrl_State = state;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (!PC_Write && (Stall_Count != {PERF_W{1'b1}}))
        Stall_Count <= Stall_Count + 1'b1;
      if ((IDEX_FLUSH || IFID_FLUSH) && (Flush_Count != {PERF_W{1'b1}}))
        Flush_Count <= Flush_Count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a behavioural model. Counter checks need HAZARD_PERF_EN.
module tb_hazard_ctrl;

  typedef struct packed {
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        pipe_hold;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, id_jump = 1'b0, ex_mem_read = 1'b0;
  logic        mem_branch_taken = 1'b0, dmem_busy = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count, flush_count;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t exp_q[$];

  // Model: a memory wait in progress, a branch owed to the wait's exit, and
  // a redirect cycle owed to the fetch latency.
  bit          m_waiting, m_branch_owed, m_redirecting;
  logic [15:0] m_stalls, m_flushes;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .ID_Rs           (id_rs),
    .ID_Rt           (id_rt),
    .ID_UsesRt       (id_uses_rt),
    .ID_Jump         (id_jump),
    .EX_Rt           (ex_rt),
    .EX_MemRead      (ex_mem_read),
    .MEM_BranchTaken (mem_branch_taken),
    .DMEM_Busy       (dmem_busy),
    .PC_Write        (pc_write),
    .IFID_Write      (ifid_write),
    .IFID_FLUSH      (ifid_flush),
    .IDEX_FLUSH      (idex_flush),
    .EXMEM_FLUSH     (exmem_flush),
    .Pipe_Hold       (pipe_hold),
`ifdef HAZARD_PERF_EN
    .Ctrl_State      (ctrl_state),
    .Stall_Count     (stall_count),
    .Flush_Count     (flush_count)
`else
    .Ctrl_State      (ctrl_state)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign stall_count = '0;
  assign flush_count = '0;
`endif

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = '{pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold,
          ctrl_state, stall_count, flush_count};
`ifndef HAZARD_PERF_EN
    a.stall_count = e.stall_count;
    a.flush_count = e.flush_count;
`endif
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      if (tests_failed <= 20)
        $display("[TB] FAIL outputs @%0t: got pc=%b ifw=%b iff=%b idf=%b emf=%b hold=%b st=%0d sc=%0d fc=%0d, want pc=%b ifw=%b iff=%b idf=%b emf=%b hold=%b st=%0d sc=%0d fc=%0d",
                 $time, a.pc_write, a.ifid_write, a.ifid_flush, a.idex_flush, a.exmem_flush,
                 a.pipe_hold, a.ctrl_state, a.stall_count, a.flush_count,
                 e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.exmem_flush,
                 e.pipe_hold, e.ctrl_state, e.stall_count, e.flush_count);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic jump, input logic [4:0] xrt, input logic mrd,
                               input logic br, input logic busy);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    reset = 1'b1;
    id_rs = rs; id_rt = rt; id_uses_rt = uses; id_jump = jump;
    ex_rt = xrt; ex_mem_read = mrd; mem_branch_taken = br; dmem_busy = busy;
    lu = mrd && (xrt != 0) && (xrt == rs || (uses && xrt == rt));
    e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
          m_waiting ? 2'b01 : (m_redirecting ? 2'b10 : 2'b00), m_stalls, m_flushes};
    if (m_redirecting) begin
      e.ifid_flush = 1'b1;
      m_redirecting = 1'b0;
    end else if (m_waiting) begin
      if (busy) begin
        e.pc_write = 0; e.ifid_write = 0; e.pipe_hold = 1;
        m_branch_owed = m_branch_owed | br;
      end else begin
        if (m_branch_owed || br) begin
          e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
          m_redirecting = 1'b1;
        end
        m_waiting = 1'b0;
        m_branch_owed = 1'b0;
      end
    end else if (busy) begin
      e.pc_write = 0; e.ifid_write = 0; e.pipe_hold = 1;
      m_waiting = 1'b1;
      m_branch_owed = br;
    end else if (br) begin
      e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
      m_redirecting = 1'b1;
    end else if (lu) begin
      e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
    end else if (jump) begin
      e.ifid_flush = 1;
    end
    if (!e.pc_write) m_stalls = sat_inc(m_stalls);
    if (e.ifid_flush || e.idex_flush) m_flushes = sat_inc(m_flushes);
    exp_q.push_back(e);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_waiting = 0; m_branch_owed = 0; m_redirecting = 0;
    m_stalls = '0; m_flushes = '0;
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'd0, 16'd0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int drain;
    applyReset();
    idle(2);

    // Load-use stall, then no stall for EX_Rt=0 and for a non-source rt
    applyStimulus(5, 9, 0, 0, 5, 1, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(3, 7, 0, 0, 7, 1, 0, 0);
    applyStimulus(3, 7, 1, 0, 7, 1, 0, 0);
    applyStimulus(3, 7, 1, 1, 0, 0, 0, 0);

    // Branch taken pulse, then branch racing a load-use and a jump
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    applyStimulus(5, 0, 0, 1, 5, 1, 1, 0);
    applyStimulus(5, 0, 0, 1, 5, 1, 0, 0);
    idle(1);

    // Busy for three cycles with a branch in the second
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Busy without branch, with a load-use frozen in ID
    applyStimulus(5, 0, 0, 0, 5, 1, 0, 1);
    applyStimulus(5, 0, 0, 0, 5, 1, 0, 0);
    applyStimulus(5, 0, 0, 0, 5, 1, 0, 0);
    idle(1);

    // Reset in the middle of a memory wait holding a pending branch
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyReset();
    idle(3);

    // Reset in the middle of a redirect
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyReset();
    idle(2);

    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 4) == 0));

`ifdef HAZARD_PERF_EN
    applyReset();
    for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    applyReset();
`else
    applyReset();
`endif
    idle(1);

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
